// File: rtl/systolic_pkg.sv
// Shared constants and controller state encoding for the 4x4 systolic array sequencer.
package systolic_pkg;

    localparam int N           = 4;
    localparam int FEED_CYCLES = 2 * N - 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } ctrl_state_t;

endpackage

// File: rtl/systolic_skew_mux.sv
// Combinational diagonal-skew selection of west (A rows) and north (B columns) feed values for feed step t.
module systolic_skew_mux
    import systolic_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [N*N-1:0][DW-1:0] a_buf,
    input  logic [N*N-1:0][DW-1:0] b_buf,
    input  logic [3:0]             t,
    output logic [N-1:0][DW-1:0]   west,
    output logic [N-1:0][DW-1:0]   north
);

    // Row i sees A[i][t-i]; column j sees B[t-j][j]; outside the diagonal band the lane is zero.
    always_comb begin
        int d;
        d     = 0;
        west  = '0;
        north = '0;
        for (int i = 0; i < N; i++) begin
            d = int'(t) - i;
            if (d >= 0 && d < N) begin
                west[i]  = a_buf[4'(i * N + d)];
                north[i] = b_buf[4'(d * N + i)];
            end
        end
    end

endmodule

// File: rtl/systolic_ctrl.sv
// Sequencer for the 4x4 output-stationary systolic array: operand buffering, clear, skewed feed, drain, done.
// Optional performance counters are enabled by defining SYSTOLIC_CTRL_PERF_EN.
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int DW           = 8,
    parameter int DRAIN_CYCLES = 7,
    parameter int CLR_CYCLES   = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic          ld_sel,
    input  logic [3:0]    ld_addr,
    input  logic [DW-1:0] ld_data,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          arr_clr,
    output logic [DW-1:0] feed_west0,
    output logic [DW-1:0] feed_west1,
    output logic [DW-1:0] feed_west2,
    output logic [DW-1:0] feed_west3,
    output logic [DW-1:0] feed_north0,
    output logic [DW-1:0] feed_north1,
    output logic [DW-1:0] feed_north2,
    output logic [DW-1:0] feed_north3
`ifdef SYSTOLIC_CTRL_PERF_EN
    ,
    output logic [15:0]   perf_busy_cyc,
    output logic [7:0]    perf_runs
`endif
);

    ctrl_state_t state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        ld_we;
    logic        done_q;

    logic [N*N-1:0][DW-1:0] a_buf, b_buf;
    logic [N-1:0][DW-1:0]   west_mux, north_mux;
    logic [N-1:0][DW-1:0]   west_q, north_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // cnt is the per-state cycle counter; in FEED it is the feed step t.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ld_ready  = 1'b0;
        busy      = 1'b0;
        arr_clr   = 1'b0;
        case (state)
            IDLE, DONE: begin
                ld_ready = 1'b1;
                if (start) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            CLEAR: begin
                busy    = 1'b1;
                arr_clr = 1'b1;
                if (cnt == 4'(CLR_CYCLES - 1)) begin
                    state_nxt = FEED;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            FEED: begin
                busy = 1'b1;
                if (cnt == 4'(FEED_CYCLES - 1)) begin
                    state_nxt = DRAIN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (cnt == 4'(DRAIN_CYCLES - 1)) begin
                    state_nxt = DONE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign ld_we = ld_valid && ld_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_buf <= '0;
            b_buf <= '0;
        end else if (ld_we) begin
            if (ld_sel) begin
                b_buf[ld_addr] <= ld_data;
            end else begin
                a_buf[ld_addr] <= ld_data;
            end
        end
    end

    // A load in DONE marks the array result stale while the state stays DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_q <= 1'b0;
        end else if (state_nxt != DONE) begin
            done_q <= 1'b0;
        end else if (state != DONE) begin
            done_q <= 1'b1;
        end else if (ld_we) begin
            done_q <= 1'b0;
        end
    end

    assign done = done_q;

    systolic_skew_mux #(
        .DW(DW)
    ) u_skew_mux (
        .a_buf (a_buf),
        .b_buf (b_buf),
        .t     (cnt_nxt),
        .west  (west_mux),
        .north (north_mux)
    );

    // Feeds are selected one cycle early from the upcoming step so the registered value lines up with FEED step t.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            west_q  <= '0;
            north_q <= '0;
        end else if (state_nxt == FEED) begin
            west_q  <= west_mux;
            north_q <= north_mux;
        end else begin
            west_q  <= '0;
            north_q <= '0;
        end
    end

    assign feed_west0  = west_q[0];
    assign feed_west1  = west_q[1];
    assign feed_west2  = west_q[2];
    assign feed_west3  = west_q[3];
    assign feed_north0 = north_q[0];
    assign feed_north1 = north_q[1];
    assign feed_north2 = north_q[2];
    assign feed_north3 = north_q[3];

`ifdef SYSTOLIC_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_busy_cyc <= '0;
            perf_runs     <= '0;
        end else begin
            if (busy && perf_busy_cyc != 16'hFFFF) begin
                perf_busy_cyc <= perf_busy_cyc + 16'd1;
            end
            if (state == DRAIN && state_nxt == DONE) begin
                perf_runs <= perf_runs + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// Self-checking bench for systolic_ctrl: scoreboard of expected feed vectors and array results checked against a behavioural 4x4 array.
module tb_systolic_ctrl;

    localparam int CLR = 1;

    typedef struct packed {
        logic [3:0][7:0] w;
        logic [3:0][7:0] n;
    } feed_t;

    logic       clk;
    logic       rst;
    logic       ld_valid;
    logic       ld_ready;
    logic       ld_sel;
    logic [3:0] ld_addr;
    logic [7:0] ld_data;
    logic       start;
    logic       busy;
    logic       done;
    logic       arr_clr;
    logic [7:0] feed_west0, feed_west1, feed_west2, feed_west3;
    logic [7:0] feed_north0, feed_north1, feed_north2, feed_north3;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  a_m [4][4];
    logic [7:0]  b_m [4][4];
    feed_t       feed_q [$];
    logic [15:0] res_q [$];
    logic [7:0]  w2_trace [7];
    logic [7:0]  n1_trace [7];

    feed_t       cur;
    logic [15:0] acc  [4][4];
    logic [7:0]  ar   [4][4];
    logic [7:0]  br   [4][4];
    logic [7:0]  pe_w [4][4];
    logic [7:0]  pe_n [4][4];

    systolic_ctrl #(
        .DW(8),
        .DRAIN_CYCLES(7),
        .CLR_CYCLES(CLR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ld_valid(ld_valid),
        .ld_ready(ld_ready),
        .ld_sel(ld_sel),
        .ld_addr(ld_addr),
        .ld_data(ld_data),
        .start(start),
        .busy(busy),
        .done(done),
        .arr_clr(arr_clr),
        .feed_west0(feed_west0),
        .feed_west1(feed_west1),
        .feed_west2(feed_west2),
        .feed_west3(feed_west3),
        .feed_north0(feed_north0),
        .feed_north1(feed_north1),
        .feed_north2(feed_north2),
        .feed_north3(feed_north3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        cur   = '0;
        cur.w = {feed_west3, feed_west2, feed_west1, feed_west0};
        cur.n = {feed_north3, feed_north2, feed_north1, feed_north0};
    end

    // Behavioural output-stationary array: A flows east, B flows south, one register per PE hop.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                pe_w[i][j] = (j == 0) ? cur.w[i] : ar[i][(j > 0) ? j - 1 : 0];
                pe_n[i][j] = (i == 0) ? cur.n[j] : br[(i > 0) ? i - 1 : 0][j];
            end
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (arr_clr) begin
                    acc[i][j] <= 16'h0;
                    ar[i][j]  <= 8'h0;
                    br[i][j]  <= 8'h0;
                end else begin
                    acc[i][j] <= acc[i][j] + ({8'h0, pe_w[i][j]} * {8'h0, pe_n[i][j]});
                    ar[i][j]  <= pe_w[i][j];
                    br[i][j]  <= pe_n[i][j];
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic feed_t exp_feed(input int t);
        feed_t r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            if (t - i >= 0 && t - i <= 3) begin
                r.w[i] = a_m[i][t - i];
                r.n[i] = b_m[t - i][i];
            end
        end
        return r;
    endfunction

    // Sums wrap at 16 bits, e.g. 4*0xFE01 becomes 0xF804.
    function automatic logic [15:0] exp_c(input int i, input int j);
        logic [15:0] s;
        s = 16'h0;
        for (int k = 0; k < 4; k++) begin
            s = s + ({8'h0, a_m[i][k]} * {8'h0, b_m[k][j]});
        end
        return s;
    endfunction

    task automatic load_all();
        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 16; a++) begin
                ld_valid = 1'b1;
                ld_sel   = s[0];
                ld_addr  = a[3:0];
                ld_data  = (s == 0) ? a_m[a / 4][a % 4] : b_m[a / 4][a % 4];
                tick();
            end
        end
        ld_valid = 1'b0;
    endtask

    // start_at / load_at inject a start or a load in the cycle numbered lat (state after lat edges from the start edge).
    task automatic run_op(input int start_at, input int load_at, input string tag);
        int    lat;
        int    t;
        feed_t e;
        logic [15:0] er;
        for (int k = 0; k < 7; k++) feed_q.push_back(exp_feed(k));
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) res_q.push_back(exp_c(i, j));
        start = 1'b1;
        tick();
        start = 1'b0;
        lat   = 1;
        checks++;
        if (arr_clr !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL %s clear_phase arr_clr=%b busy=%b expected 1 1", tag, arr_clr, busy);
        end
        while (lat < 60) begin
            if (lat > CLR && lat <= CLR + 7 && feed_q.size() > 0) begin
                t = lat - CLR - 1;
                e = feed_q.pop_front();
                w2_trace[t] = feed_west2;
                n1_trace[t] = feed_north1;
                for (int l = 0; l < 4; l++) begin
                    checks++;
                    if (cur.w[l] !== e.w[l]) begin
                        failures++;
                        $display("[TB] FAIL %s feed t=%0d west%0d got=%h expected=%h", tag, t, l, cur.w[l], e.w[l]);
                    end
                    checks++;
                    if (cur.n[l] !== e.n[l]) begin
                        failures++;
                        $display("[TB] FAIL %s feed t=%0d north%0d got=%h expected=%h", tag, t, l, cur.n[l], e.n[l]);
                    end
                end
            end
            if (done === 1'b1) break;
            start = (lat == start_at);
            if (lat == load_at) begin
                ld_valid = 1'b1;
                ld_sel   = 1'b0;
                ld_addr  = 4'd0;
                ld_data  = 8'h55;
                checks++;
                if (ld_ready !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL %s ld_ready_while_busy got=%b expected=0", tag, ld_ready);
                end
            end else begin
                ld_valid = 1'b0;
            end
            tick();
            lat++;
        end
        start    = 1'b0;
        ld_valid = 1'b0;
        checks++;
        if (done !== 1'b1 || lat != 16) begin
            failures++;
            $display("[TB] FAIL %s latency got=%0d done=%b expected=16 done=1", tag, lat, done);
        end
        feed_q.delete();
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                er = res_q.pop_front();
                checks++;
                if (acc[i][j] !== er) begin
                    failures++;
                    $display("[TB] FAIL %s result[%0d][%0d] got=%h expected=%h", tag, i, j, acc[i][j], er);
                end
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        checks++;
        if (ld_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || arr_clr !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s ctrl ld_ready=%b busy=%b done=%b arr_clr=%b expected 1 0 0 0",
                     tag, ld_ready, busy, done, arr_clr);
        end
        checks++;
        if (cur !== '0) begin
            failures++;
            $display("[TB] FAIL %s feeds got=%h expected=0", tag, cur);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        check_idle_outputs("reset");
        rst = 1'b1;
        tick();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                a_m[i][j] = (i == j) ? 8'd1 : 8'd0;
                b_m[i][j] = 8'(4 * i + j + 1);
            end
        load_all();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (busy !== 1'b1 || cur === '0) begin
            failures++;
            $display("[TB] FAIL reset_midfeed_setup busy=%b feeds=%h expected busy=1 feeds nonzero", busy, cur);
        end
        #2 rst = 1'b0;
        #1;
        check_idle_outputs("reset_midfeed");
        tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                a_m[i][j] = 8'd0;
                b_m[i][j] = 8'd0;
            end
        run_op(-1, -1, "post_reset");
    endtask

    task automatic test_identity();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                a_m[i][j] = (i == j) ? 8'd1 : 8'd0;
                b_m[i][j] = 8'(4 * i + j + 1);
            end
        load_all();
        run_op(-1, -1, "identity");
        checks++;
        if (n1_trace[1] !== 8'd2) begin
            failures++;
            $display("[TB] FAIL identity north1_t1 got=%h expected=02", n1_trace[1]);
        end
    endtask

    task automatic test_all_ones();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                a_m[i][j] = 8'h01;
                b_m[i][j] = 8'h01;
            end
        load_all();
        run_op(-1, -1, "ones");
        run_op(-1, -1, "ones_rerun");
    endtask

    task automatic test_max();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                a_m[i][j] = 8'hFF;
                b_m[i][j] = 8'hFF;
            end
        load_all();
        run_op(-1, -1, "max");
    endtask

    task automatic test_handshake();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                a_m[i][j] = 8'(i + j + 1);
                b_m[i][j] = 8'(2 * i + j);
            end
        load_all();
        run_op(CLR + 9, CLR + 3, "handshake");
        tick();
        tick();
        tick();
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL done_hold got=%b expected=1", done);
        end
        ld_valid = 1'b1;
        ld_sel   = 1'b1;
        ld_addr  = 4'd5;
        ld_data  = 8'h09;
        b_m[1][1] = 8'h09;
        tick();
        ld_valid = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || ld_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL load_in_done done=%b busy=%b ld_ready=%b expected 0 0 1", done, busy, ld_ready);
        end
        run_op(-1, -1, "after_done_load");
    endtask

    task automatic test_skew();
        logic [7:0] w2_exp [7];
        w2_exp = '{8'h00, 8'h00, 8'h20, 8'h21, 8'h22, 8'h23, 8'h00};
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                a_m[i][k] = 8'(16 * i + k);
                b_m[i][k] = 8'h01;
            end
        load_all();
        run_op(-1, -1, "skew");
        for (int t = 0; t < 7; t++) begin
            checks++;
            if (w2_trace[t] !== w2_exp[t]) begin
                failures++;
                $display("[TB] FAIL skew west2 t=%0d got=%h expected=%h", t, w2_trace[t], w2_exp[t]);
            end
        end
    endtask

    initial begin
        rst      = 1'b0;
        ld_valid = 1'b0;
        ld_sel   = 1'b0;
        ld_addr  = 4'd0;
        ld_data  = 8'd0;
        start    = 1'b0;
        test_reset();
        test_identity();
        test_all_ones();
        test_max();
        test_handshake();
        test_skew();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
